// File: rtl/gpu_pkg.sv
// Shared job types and helpers for the triangle front-end.
package gpu_pkg;

  localparam int DEF_COORD_W = 16;
  localparam int DEF_COLOR_W = 16;
  localparam int BOUNDS_W    = 9 * DEF_COORD_W;

  // One triangle job: flat bounds vector in the upper bits, flat color below.
  typedef struct packed {
    logic [BOUNDS_W-1:0]    bounds;
    logic [DEF_COLOR_W-1:0] color;
  } tri_job_t;

  // Vertex v, coord c lands at bits [(3v+c)*W +: W] of the flat vector.
  function automatic logic [BOUNDS_W-1:0] pack_bounds(input logic [DEF_COORD_W-1:0] b [3][3]);
    logic [BOUNDS_W-1:0] flat;
    flat = '0;
    for (int v = 0; v < 3; v++) begin
      for (int c = 0; c < 3; c++) begin
        flat[(3*v+c)*DEF_COORD_W +: DEF_COORD_W] = b[v][c];
      end
    end
    return flat;
  endfunction

endpackage

// File: rtl/job_fifo.sv
// Synchronous job FIFO; full/empty come from registered pointers only,
// so a pop never frees a slot for a push in the same cycle.
module job_fifo #(
  parameter int WIDTH = 160,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/triangle_dispatcher.sv
// Buffers triangle jobs and hands each to an idle core, round-robin,
// tracking per-core busy flags and signalling frame completion.
// Input handshake: a job transfers on a rising clk edge where in_valid and
// in_ready are both high; in_ready depends only on registered FIFO state.
module triangle_dispatcher
  import gpu_pkg::*;
#(
  parameter int COORD_WIDTH = DEF_COORD_W,
  parameter int COLOR_WIDTH = DEF_COLOR_W,
  parameter int CORES_COUNT = 10,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [9*COORD_WIDTH-1:0] in_bounds,
  input  logic [COLOR_WIDTH-1:0]   in_color,
  input  logic                     frame_end,
  output logic [CORES_COUNT-1:0]   core_start,
  output logic [9*COORD_WIDTH-1:0] core_bounds,
  output logic [COLOR_WIDTH-1:0]   core_color,
  input  logic [CORES_COUNT-1:0]   core_eoc,
  output logic [CORES_COUNT-1:0]   busy_mask,
  output logic                     frame_done,
  output logic                     err_spurious
);

  localparam int BW    = 9 * COORD_WIDTH;
  localparam int JOB_W = BW + COLOR_WIDTH;
  localparam int RR_W  = (CORES_COUNT > 1) ? $clog2(CORES_COUNT) : 1;
  localparam logic [RR_W-1:0] RR_LAST = RR_W'(CORES_COUNT - 1);

  logic                   fifo_full, fifo_empty;
  logic [JOB_W-1:0]       fifo_head;
  logic                   push, dispatch;
  logic [CORES_COUNT-1:0] idle, grant_vec;
  logic [RR_W-1:0]        grant_idx;
  logic                   done_now;

  logic [CORES_COUNT-1:0] busy_q, busy_d;
  logic [CORES_COUNT-1:0] start_q, start_d;
  logic [BW-1:0]          bounds_q, bounds_d;
  logic [COLOR_WIDTH-1:0] color_q, color_d;
  logic [RR_W-1:0]        rr_q, rr_d;
  logic                   pending_q, pending_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  // Lowest idle core at or above ptr, else lowest idle core overall.
  function automatic logic [RR_W-1:0] rr_pick(input logic [CORES_COUNT-1:0] free,
                                              input logic [RR_W-1:0] ptr);
    logic [RR_W-1:0] pick;
    logic            found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < CORES_COUNT; i++) begin
      if (!found && free[i] && (RR_W'(i) >= ptr)) begin
        found = 1'b1;
        pick  = RR_W'(i);
      end
    end
    for (int i = 0; i < CORES_COUNT; i++) begin
      if (!found && free[i]) begin
        found = 1'b1;
        pick  = RR_W'(i);
      end
    end
    return pick;
  endfunction

  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;
  assign idle     = ~busy_q;
  assign dispatch = !fifo_empty && (|idle);

  job_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (dispatch),
    .wdata_i ({in_bounds, in_color}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Grant, busy tracking, round-robin pointer and frame completion.
  always_comb begin
    grant_idx = rr_pick(idle, rr_q);
    grant_vec = dispatch ? (CORES_COUNT'(1) << grant_idx) : '0;
    start_d   = grant_vec;
    bounds_d  = dispatch ? fifo_head[JOB_W-1:COLOR_WIDTH] : bounds_q;
    color_d   = dispatch ? fifo_head[COLOR_WIDTH-1:0] : color_q;
    rr_d      = rr_q;
    if (dispatch) rr_d = (grant_idx == RR_LAST) ? '0 : grant_idx + RR_W'(1);
    // eoc from an idle core is dropped and only flagged.
    busy_d    = (busy_q & ~core_eoc) | grant_vec;
    err_d     = err_q | (|(core_eoc & ~busy_q));
    done_now  = pending_q && fifo_empty && !(|start_q) && !(|busy_q);
    done_d    = done_now;
    // A frame_end while one is already pending merges into it.
    pending_d = pending_q ? !done_now : frame_end;
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= '0;
      start_q   <= '0;
      bounds_q  <= '0;
      color_q   <= '0;
      rr_q      <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      start_q   <= start_d;
      bounds_q  <= bounds_d;
      color_q   <= color_d;
      rr_q      <= rr_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign core_start   = start_q;
  assign core_bounds  = bounds_q;
  assign core_color   = color_q;
  assign busy_mask    = busy_q;
  assign frame_done   = done_q;
  assign err_spurious = err_q;

endmodule
